// File: rtl/axi_op_pkg.sv
// Shared types and response codes for the AXI-lite operand/result initiator.
package axi_op_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrAddrData,
        StWrResp,
        StRdAddr,
        StRdData,
        StDone
    } state_e;

    localparam logic [1:0] RespOkay    = 2'b00;
    localparam logic [1:0] RespExokay  = 2'b01;
    localparam logic [1:0] RespSlverr  = 2'b10;
    localparam logic [1:0] RespDecerr  = 2'b11;
    localparam logic [1:0] RespTimeout = 2'b11;

endpackage

// File: rtl/axi_op_timer.sv
// Wait-state watchdog: counts enabled cycles since the last clear and flags
// the TIMEOUT-th one.
module axi_op_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] Limit = 16'(TIMEOUT - 1);

    logic [15:0] cnt_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    // Must not depend on clear: clear is derived from the FSM's next state.
    assign expired = enable && (cnt_q == Limit);

endmodule

// File: rtl/axi_op_master.sv
// Single-outstanding AXI-lite initiator: one result write or one operand-pair
// read per command, with a watchdog so a stalled slave cannot hang the caller.
module axi_op_master
    import axi_op_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned OP_W    = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr1,
    input  logic [ADDR_W-1:0] cmd_addr2,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    output logic              rsp_err,
    output logic [OP_W-1:0]   rsp_rdata1,
    output logic [OP_W-1:0]   rsp_rdata2,
    output logic              M_awvalid,
    output logic              M_wvalid,
    output logic              M_bready,
    output logic              M_arvalid,
    output logic              M_rready,
    output logic [ADDR_W-1:0] M_waddr,
    output logic [ADDR_W-1:0] M_Raddr1,
    output logic [ADDR_W-1:0] M_Raddr2,
    output logic [DATA_W-1:0] M_wdata,
    input  logic              S_awready,
    input  logic              S_wready,
    input  logic              S_bvalid,
    input  logic              S_arready,
    input  logic              S_rvalid,
    input  logic [1:0]        S_bresp,
    input  logic [1:0]        S_rresp,
    input  logic [OP_W-1:0]   S_rdata1,
    input  logic [OP_W-1:0]   S_rdata2
);

    state_e            state_q, state_d;
    logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d, raddr1_q, raddr1_d, raddr2_q, raddr2_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        resp_q, resp_d;
    logic              tmo_q, tmo_d;
    logic [OP_W-1:0]   rdata1_q, rdata1_d, rdata2_q, rdata2_d;
    logic              timer_clear, timer_enable, expired;

    assign timer_enable = (state_q != StIdle) && (state_q != StDone);
    assign timer_clear  = (state_d != state_q);

    axi_op_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (expired)
    );

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        waddr_d   = waddr_q;
        raddr1_d  = raddr1_q;
        raddr2_d  = raddr2_q;
        wdata_d   = wdata_q;
        resp_d    = resp_q;
        tmo_d     = tmo_q;
        rdata1_d  = rdata1_q;
        rdata2_d  = rdata2_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (cmd_write) begin
                        waddr_d = cmd_addr1;
                        wdata_d = cmd_wdata;
                        state_d = StWrAddrData;
                    end else begin
                        raddr1_d = cmd_addr1;
                        raddr2_d = cmd_addr2;
                        state_d  = StRdAddr;
                    end
                end
            end
            StWrAddrData: begin
                aw_done_d = aw_done_q | S_awready;
                w_done_d  = w_done_q | S_wready;
                if (aw_done_d && w_done_d) begin
                    state_d = StWrResp;
                end else if (expired) begin
                    state_d = StDone;
                    resp_d  = RespTimeout;
                    tmo_d   = 1'b1;
                end
            end
            StWrResp: begin
                if (S_bvalid) begin
                    state_d = StDone;
                    resp_d  = S_bresp;
                    tmo_d   = 1'b0;
                end else if (expired) begin
                    state_d = StDone;
                    resp_d  = RespTimeout;
                    tmo_d   = 1'b1;
                end
            end
            StRdAddr: begin
                if (S_arready) begin
                    state_d = StRdData;
                end else if (expired) begin
                    state_d = StDone;
                    resp_d  = RespTimeout;
                    tmo_d   = 1'b1;
                end
            end
            StRdData: begin
                if (S_rvalid) begin
                    state_d  = StDone;
                    resp_d   = S_rresp;
                    tmo_d    = 1'b0;
                    rdata1_d = S_rdata1;
                    rdata2_d = S_rdata2;
                end else if (expired) begin
                    state_d = StDone;
                    resp_d  = RespTimeout;
                    tmo_d   = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= StIdle;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            waddr_q   <= '0;
            raddr1_q  <= '0;
            raddr2_q  <= '0;
            wdata_q   <= '0;
            resp_q    <= '0;
            tmo_q     <= 1'b0;
            rdata1_q  <= '0;
            rdata2_q  <= '0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            waddr_q   <= waddr_d;
            raddr1_q  <= raddr1_d;
            raddr2_q  <= raddr2_d;
            wdata_q   <= wdata_d;
            resp_q    <= resp_d;
            tmo_q     <= tmo_d;
            rdata1_q  <= rdata1_d;
            rdata2_q  <= rdata2_d;
        end
    end

    // Valids/readies decode registered state only, so they never follow a ready combinationally.
    assign M_awvalid   = (state_q == StWrAddrData) && !aw_done_q;
    assign M_wvalid    = (state_q == StWrAddrData) && !w_done_q;
    assign M_bready    = (state_q == StWrResp);
    assign M_arvalid   = (state_q == StRdAddr);
    assign M_rready    = (state_q == StRdData);
    assign M_waddr     = waddr_q;
    assign M_wdata     = wdata_q;
    assign M_Raddr1    = raddr1_q;
    assign M_Raddr2    = raddr2_q;
    assign cmd_ready   = (state_q == StIdle);
    assign rsp_valid   = (state_q == StDone);
    assign rsp_resp    = resp_q;
    assign rsp_timeout = tmo_q;
    assign rsp_err     = resp_q[1] | tmo_q;
    assign rsp_rdata1  = rdata1_q;
    assign rsp_rdata2  = rdata2_q;

endmodule

// File: doc/axi_op_master.md
Name: axi_op_master

Overview:
- AXI-lite style initiator that drives the operand/result slave from the master side.
- Accepts one command at a time from a local controller.
  - Write command: result word to a write address.
  - Read command: operand pair, two 16-bit words at two read addresses.
- Runs the AW/W/B or AR/R handshakes, then returns the response code and read data to the controller.
- Sits between the top-level sequencer and the slave's M_*/S_* port group. Includes a handshake timeout so a stalled slave cannot hang the sequencer.

Parameters:
- ADDR_W, 32, address width of waddr/raddr1/raddr2
- DATA_W, 32, write data / result width
- OP_W, 16, width of each read operand
- TIMEOUT, 255, max cycles spent in any wait state before abort (1..2^16-1)

Ports:
- PCLK  in  1  clock
- PRESET  in  1  reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1=write, 0=read
- cmd_addr1  in  ADDR_W  write address (write) / operand-1 address (read)
- cmd_addr2  in  ADDR_W  operand-2 address (read only)
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_resp  out  2  captured BRESP/RRESP; 2'b11 on timeout
- rsp_timeout  out  1  completion caused by timeout
- rsp_err  out  1  rsp_resp[1] | rsp_timeout
- rsp_rdata1  out  OP_W  captured operand 1
- rsp_rdata2  out  OP_W  captured operand 2
- M_awvalid, M_wvalid, M_bready, M_arvalid, M_rready  out  1 each  AXI valids/readies
- M_waddr, M_Raddr1, M_Raddr2  out  ADDR_W  AXI addresses
- M_wdata  out  DATA_W  AXI write data
- S_awready, S_wready, S_bvalid, S_arready, S_rvalid  in  1 each
- S_bresp, S_rresp  in  2
- S_rdata1, S_rdata2  in  OP_W

Behaviour:
- Clocking and reset: clock PCLK; reset PRESET, asynchronous, active-high.
- Reset values:
  - All M_* valids/readies = 0; addresses and data = 0.
  - rsp_* = 0.
  - State = IDLE, cmd_ready = 1.
  - A reset mid-transaction drops all valids immediately and discards the pending command.
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE:
  - On cmd_valid at a clock edge, latch addr1/addr2/wdata onto the M_* address/data outputs.
  - Next state is WR_ADDR_DATA (cmd_write=1) or RD_ADDR.
- WR_ADDR_DATA:
  - M_awvalid and M_wvalid rise together on entry.
  - Each drops independently on the edge where its own ready is sampled high; aw_done/w_done flags track this.
  - Both done leads to WR_RESP. The order of handshakes and same-cycle handshakes are both legal.
- WR_RESP:
  - M_bready = 1.
  - S_bvalid sampled high: capture S_bresp, go to DONE. An S_bvalid arriving before WR_RESP is ignored; bready is low then, so the slave holds it.
- RD_ADDR:
  - M_arvalid = 1 with M_Raddr1/M_Raddr2 stable until S_arready is sampled high, then go to RD_DATA.
- RD_DATA:
  - M_rready = 1.
  - S_rvalid sampled high: capture S_rdata1/S_rdata2/S_rresp, go to DONE.
- DONE:
  - rsp_valid = 1 for exactly one cycle, then IDLE.
  - rsp_* data and resp hold their values until the next completion.
- Valid/ready rules:
  - Valids never depend combinationally on the slave's readies.
  - Addresses and data are stable while the corresponding valid is high.
- Latency:
  - Write minimum: accept at T0, AW/W handshake at T1, B at T2, rsp_valid during T3.
  - Read: same timing.
- Timeout:
  - A 16-bit counter clears on every state entry and increments in each wait state.
  - When the count reaches TIMEOUT: drop all valids/readies, set rsp_resp=2'b11 and rsp_timeout=1, go to DONE.
  - Read data is not updated on timeout.
- Ready present on the first cycle: if a ready/valid is already high when the state is entered, the handshake completes on that first edge.
- Writes never touch rsp_rdata1/2.

Decomposition:
- Package axi_op_pkg:
  - state enum
  - response constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11
  - timeout code 2'b11
- Sub-module axi_op_timer: clear/enable inputs, TIMEOUT parameter, single-cycle expired output. Everything else stays in the top FSM.

Test Plan:
- Write, ready slave:
  - Stimulus: cmd_write=1, addr1=0x10, wdata=0x0001_0002; slave holds awready/wready=1, bvalid one cycle later with bresp=00.
  - Expect: AW/W asserted exactly 1 cycle; rsp_valid 3 cycles after accept; rsp_resp=00, rsp_err=0.
- Split write handshake:
  - Stimulus: awready after 2 cycles, wready after 5 cycles.
  - Expect: awvalid drops after cycle 2, wvalid held until cycle 5; bready rises only after both; single rsp_valid.
- Read:
  - Stimulus: addr1=0x4, addr2=0x8; slave returns rdata1=0x1234, rdata2=0xABCD, rresp=00 after 3-cycle rvalid delay.
  - Expect: rsp_rdata1=0x1234, rsp_rdata2=0xABCD, rsp_err=0.
- Error response:
  - Stimulus: read with rresp=10.
  - Expect: rsp_resp=10, rsp_err=1, rsp_timeout=0.
- Timeout:
  - Stimulus: TIMEOUT=8, slave never asserts arready.
  - Expect: arvalid drops after 8 cycles; rsp_resp=11, rsp_timeout=1; cmd_ready returns next cycle.
- Reset mid-write:
  - Stimulus: assert PRESET while in WR_RESP.
  - Expect: all M_* = 0 asynchronously, cmd_ready=1 after release, no rsp_valid.
